muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS CPU. It consumes the two register-file read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU over a fixed number of cycles, holding the result in HI/LO until a later MFHI/MFLO. It also services MTHI/MTLO writes and gives the control FSM a Busy/Done handshake so that it can stall.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/negate64.sv | 13 +
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the iteration count.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 5;

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/negate64.sv
// Combinational two's-complement negate with enable; passes the value
// through unchanged when en is low.
module negate64 #(
    parameter int W = 64
) (
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: magnitudes are
// processed for 32 cycles, sign-corrected in FIX and committed in DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_e             stateReg;
    logic [CNT_W-1:0]   iterCnt;
    logic               isDivReg;
    logic               negAReg;
    logic               negBReg;
    logic               divZeroReg;
    logic [WIDTH-1:0]   magAReg;
    logic [WIDTH-1:0]   magBReg;
    logic [WIDTH-1:0]   rawAReg;
    logic [2*WIDTH-1:0] accReg;

    logic               signedOp;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;

    assign signedOp = isSignedOp(Op);
    assign aNeg     = signedOp & OperandA[WIDTH-1];
    assign bNeg     = signedOp & OperandB[WIDTH-1];
    assign absA     = aNeg ? (~OperandA + WIDTH'(1)) : OperandA;
    assign absB     = bNeg ? (~OperandB + WIDTH'(1)) : OperandB;

    // Shift-add: accumulator holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;

    assign mulSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]} + {1'b0, magAReg};
    assign mulNext = accReg[0] ? {mulSum, accReg[WIDTH-1:1]}
                               : {1'b0, accReg[2*WIDTH-1:1]};

    // Restoring division: accumulator holds {remainder, dividend/quotient}.
    logic [WIDTH:0]     divShift;
    logic [WIDTH+1:0]   divDiff;
    logic [2*WIDTH-1:0] divNext;

    assign divShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
    assign divDiff  = {1'b0, divShift} - {2'b00, magBReg};
    assign divNext  = divDiff[WIDTH+1]
                    ? {divShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0}
                    : {divDiff[WIDTH-1:0],  accReg[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] lowFixed;
    logic [2*WIDTH-1:0] remFixed;
    logic [2*WIDTH-1:0] fixedAcc;
    logic               unusedBits;

    // Product (or quotient) flips when signs differ; remainder follows the dividend.
    negate64 #(.W(2*WIDTH)) uNegLow (
        .en     (negAReg ^ negBReg),
        .value  (isDivReg ? {{WIDTH{1'b0}}, accReg[WIDTH-1:0]} : accReg),
        .result (lowFixed)
    );

    negate64 #(.W(2*WIDTH)) uNegRem (
        .en     (isDivReg & negAReg),
        .value  ({{WIDTH{1'b0}}, accReg[2*WIDTH-1:WIDTH]}),
        .result (remFixed)
    );

    assign fixedAcc   = isDivReg ? {remFixed[WIDTH-1:0], lowFixed[WIDTH-1:0]} : lowFixed;
    assign unusedBits = ^{divDiff[WIDTH], remFixed[2*WIDTH-1:WIDTH]};

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stateReg   <= ST_IDLE;
            iterCnt    <= '0;
            isDivReg   <= 1'b0;
            negAReg    <= 1'b0;
            negBReg    <= 1'b0;
            divZeroReg <= 1'b0;
            magAReg    <= '0;
            magBReg    <= '0;
            rawAReg    <= '0;
            accReg     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Hi         <= '0;
            Lo         <= '0;
        end else begin
            Done <= 1'b0;
            case (stateReg)
                ST_IDLE: begin
                    if (Start) begin
                        isDivReg   <= Op[1];
                        negAReg    <= aNeg;
                        negBReg    <= bNeg;
                        divZeroReg <= Op[1] && (OperandB == '0);
                        magAReg    <= absA;
                        magBReg    <= absB;
                        rawAReg    <= OperandA;
                        accReg     <= Op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                        iterCnt    <= '0;
                        Busy       <= 1'b1;
                        stateReg   <= ST_RUN;
                    end else begin
                        if (WriteHi) Hi <= WriteData;
                        if (WriteLo) Lo <= WriteData;
                    end
                end
                ST_RUN: begin
                    accReg  <= isDivReg ? divNext : mulNext;
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (iterCnt == CNT_W'(ITER_COUNT - 1)) stateReg <= ST_FIX;
                end
                ST_FIX: begin
                    accReg   <= fixedAcc;
                    stateReg <= ST_DONE;
                end
                ST_DONE: begin
                    // Divide by zero reports the raw dividend in HI, not the sign-fixed one.
                    if (divZeroReg) begin
                        Hi <= rawAReg;
                        Lo <= '1;
                    end else begin
                        Hi <= accReg[2*WIDTH-1:WIDTH];
                        Lo <= accReg[WIDTH-1:0];
                    end
                    Done     <= 1'b1;
                    Busy     <= 1'b0;
                    stateReg <= ST_IDLE;
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

endmodule
